// File: rtl/apb_arbiter_master.sv
// Two-requester round-robin arbiter driving a single APB master port.
// Each granted transfer ends with one done pulse, which carries rsp_err=1 if the slave timed out.
module apb_arbiter_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic        req0_write,
    input  logic        req1_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req0_wdata,
    input  logic [31:0] req1_wdata,
    output logic        req0_done,
    output logic        req1_done,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        ACCESS   = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    // Counter value seen in the last ACCESS cycle before the transfer is abandoned
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        gnt_s;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        rdata_d      = rdata_q;
        err_d        = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        gnt_s        = last_grant_q;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    // On a tie the requester not served last wins
                    if (req0_valid && req1_valid) begin
                        gnt_s = ~last_grant_q;
                    end else begin
                        gnt_s = req1_valid;
                    end
                    last_grant_d = gnt_s;
                    pwrite_d     = gnt_s ? req1_write : req0_write;
                    paddr_d      = gnt_s ? req1_addr  : req0_addr;
                    pwdata_d     = gnt_s ? req1_wdata : req0_wdata;
                    psel_d       = 1'b1;
                    state_d      = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                cnt_d     = 8'd0;
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // PREADY wins over an expiring counter
                if (PREADY) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done0_d   = ~last_grant_q;
                    done1_d   = last_grant_q;
                    if (!pwrite_q) begin
                        rdata_d = PRDATA;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d = COMPLETE;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d     = cnt_q + 8'd1;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done0_d   = ~last_grant_q;
                    done1_d   = last_grant_q;
                    err_d     = 1'b1;
                    rdata_d   = 32'h0000_0000;
                    state_d   = COMPLETE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = ACCESS;
                end
            end
            COMPLETE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= 8'd0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= 32'h0000_0000;
            pwdata_q     <= 32'h0000_0000;
            rdata_q      <= 32'h0000_0000;
            err_q        <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign req0_done = done0_q;
    assign req1_done = done1_q;

endmodule

// File: doc/apb_arbiter_master.md
APB_ARBITER_MASTER -- requirements
Module: apb_arbiter_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum ACCESS-phase cycles to wait for PREADY; legal range 1..255.
REQ-002 SHALL have port PCLK, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port PRESET, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester N has a transfer pending.
REQ-005 SHALL have ports req0_write and req1_write, input, 1 bit each: 1 = write, 0 = read.
REQ-006 SHALL have ports req0_addr and req1_addr, input, 32 bits each: target register address.
REQ-007 SHALL have ports req0_wdata and req1_wdata, input, 32 bits each: write data.
REQ-008 SHALL have ports req0_done and req1_done, output, 1 bit each: one-cycle completion pulse to requester N.
REQ-009 SHALL have port rsp_rdata, output, 32 bits: read data of the last completed read.
REQ-010 SHALL have port rsp_err, output, 1 bit: valid with doneN; 1 = timeout abort.
REQ-011 SHALL have APB master ports PSEL, PENABLE and PWRITE, output, 1 bit each; PADDR and PWDATA, output, 32 bits each.
REQ-012 SHALL have APB ports PRDATA, input, 32 bits; PREADY, input, 1 bit.

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, ACCESS and COMPLETE; all outputs registered.
REQ-014 IDLE: if any reqN_valid, SHALL latch the granted requester's write, addr and wdata into PWRITE, PADDR and PWDATA, set PSEL=1 and go to SETUP; otherwise stay in IDLE.
REQ-015 SHALL arbitrate round-robin: a lone requester wins; if both are valid, the one not granted last wins; last_grant resets to 1, so req0 wins the first tie.
REQ-016 SETUP: SHALL hold PSEL=1 and PENABLE=0 for exactly one cycle, clear the timeout counter, then go to ACCESS with PENABLE=1.
REQ-017 ACCESS: SHALL hold PSEL, PENABLE, PWRITE, PADDR and PWDATA stable; the timeout counter (8 bits) increments each cycle PREADY=0.
REQ-018 ACCESS with PREADY=1 sampled: SHALL go to COMPLETE, clear PSEL and PENABLE, and pulse done to the granted requester with rsp_err=0.
REQ-019 On completion of a read, SHALL capture PRDATA into rsp_rdata at that edge; on a write, rsp_rdata is unchanged.
REQ-020 ACCESS with counter reaching TIMEOUT and PREADY=0: SHALL go to COMPLETE, clear PSEL and PENABLE, pulse done with rsp_err=1 and set rsp_rdata=0.
REQ-021 COMPLETE: doneN and rsp_err SHALL be high for exactly this one cycle, then the FSM returns to IDLE; no arbitration takes place in COMPLETE.
REQ-022 Requester protocol: hold valid and fields stable until its done pulse; drop valid in the done cycle or the next IDLE treats it as a new request.
REQ-023 Dropping reqN_valid or changing reqN fields after the grant SHALL NOT affect the transfer in flight.
REQ-024 PREADY outside ACCESS SHALL be ignored.
REQ-025 Simultaneous PREADY=1 and counter==TIMEOUT SHALL be treated as success (rsp_err=0).
REQ-026 Minimum transfer SHALL be 5 cycles with a 1-cycle-late PREADY: IDLE(valid), SETUP, ACCESS, ACCESS(PREADY), COMPLETE; the next grant is possible in the following IDLE.
REQ-027 Exactly one doneN SHALL pulse per granted transfer, and never both in the same cycle.

Reset
REQ-028 PRESET=1 SHALL asynchronously force state=IDLE, last_grant=1, counter=0, and PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_rdata, rsp_err, req0_done and req1_done all to 0.
REQ-029 Reset during SETUP, ACCESS or COMPLETE SHALL abort the transfer with no done pulse; after release, pending requests re-arbitrate from the reset state.

Verification
REQ-030 Write: req0 write, addr 0x4, wdata 0x12345678; slave PREADY one cycle into ACCESS -> PSEL high 3 cycles, PENABLE 2 cycles, req0_done pulse with rsp_err=0, slave register 0x4 = 0x12345678.
REQ-031 Readback: req1 read addr 0x4 after REQ-030 -> req1_done pulse, rsp_rdata=0x12345678, PWRITE=0 throughout.
REQ-032 Tie: both valid in the same cycle after reset -> req0 granted first, req1 next; held for 4 transfers -> grant order 0,1,0,1.
REQ-033 Timeout: TIMEOUT=4, PREADY tied 0 -> ACCESS lasts 4 cycles, done pulse with rsp_err=1 and rsp_rdata=0, PSEL low next cycle.
REQ-034 Reset mid-ACCESS: assert PRESET while PENABLE=1 -> all outputs 0 immediately, no done pulse; after release the still-valid requester is re-granted.
REQ-035 Stray PREADY=1 while IDLE or SETUP -> no state change, no done pulse.
